// File: rtl/scan_code_display_sequencer.sv
// scan_code_display_sequencer
//   Sits between the PS/2 keyboard receiver and the seven-segment controller.
//   Filters PS/2 protocol bytes (E0 extended prefix, F0 break prefix, released
//   key codes, typematic repeats) and keeps the last four pressed make codes
//   as a 32-bit display word. Also runs the digit multiplex schedule.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset (deassertion synchronised)
//   i_code_valid   i_code_data holds a received keyboard byte
//   i_code_data    keyboard byte
//   o_code_ready   sequencer accepts a byte this cycle (low only in SHIFT)
//   o_scan_codes   key history, [7:0] newest, [31:24] oldest, 8'h00 = empty
//   o_digit_sel    digit currently driven, 0..3
//   o_digit_tick   one-cycle pulse on the cycle digit_sel advances
//
// state | meaning
// IDLE  | no key held, waiting for a make code or break prefix
// HELD  | last_make is held down; identical bytes are typematic repeats
// BREAK | F0 seen, next byte is a released-key code
// SHIFT | one cycle: push pending code into the history (or clear it)
module scan_code_display_sequencer #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter logic [7:0]  CLEAR_CODE  = 8'h66
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_code_valid,
  input  logic [7:0]  i_code_data,
  output logic        o_code_ready,
  output logic [31:0] o_scan_codes,
  output logic [1:0]  o_digit_sel,
  output logic        o_digit_tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] NULL_CODE  = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HELD  = 2'd1,
    S_BREAK = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  // Reset asserts asynchronously and releases on the first clk edge after
  // reset_n rises; every other flop uses this synchronised reset.
  logic r_rst_sync;
  logic w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 1'b0;
    else          r_rst_sync <= 1'b1;
  end

  assign w_rst_n = r_rst_sync;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_pending;
  logic [7:0]  w_pending_nxt;
  logic [7:0]  r_last_make;
  logic [7:0]  w_last_make_nxt;
  logic [31:0] r_scan_codes;
  logic [31:0] w_scan_nxt;
  logic        w_accept;
  logic        w_byte_usable;

  assign o_code_ready  = r_rst_sync && (r_state != S_SHIFT);
  assign w_accept      = i_code_valid && o_code_ready;
  // E0 and 00 never change state or data, so they are filtered up front.
  assign w_byte_usable = w_accept && (i_code_data != EXT_CODE) &&
                         (i_code_data != NULL_CODE);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_pending    <= 8'h00;
      r_last_make  <= 8'h00;
      r_scan_codes <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= w_pending_nxt;
      r_last_make  <= w_last_make_nxt;
      r_scan_codes <= w_scan_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_last_make_nxt = r_last_make;
    w_scan_nxt      = r_scan_codes;
    case (r_state)
      S_SHIFT: begin
        w_state_nxt = S_HELD;
        if (r_pending == CLEAR_CODE) w_scan_nxt = 32'h0;
        else                         w_scan_nxt = {r_scan_codes[23:0], r_pending};
      end
      S_IDLE: begin
        if (w_byte_usable) begin
          if (i_code_data == BREAK_CODE) begin
            w_state_nxt = S_BREAK;
          end else begin
            w_pending_nxt   = i_code_data;
            w_last_make_nxt = i_code_data;
            w_state_nxt     = S_SHIFT;
          end
        end
      end
      S_HELD: begin
        if (w_byte_usable) begin
          if (i_code_data == BREAK_CODE) begin
            w_state_nxt = S_BREAK;
          end else if (i_code_data != r_last_make) begin
            w_pending_nxt   = i_code_data;
            w_last_make_nxt = i_code_data;
            w_state_nxt     = S_SHIFT;
          end
        end
      end
      S_BREAK: begin
        if (w_byte_usable) begin
          // Releasing the held key returns to IDLE; releasing some other key
          // leaves the held key still down.
          if (i_code_data == r_last_make) begin
            w_last_make_nxt = 8'h00;
            w_state_nxt     = S_IDLE;
          end else begin
            w_state_nxt = S_HELD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_scan_codes = r_scan_codes;

  // Free-running refresh scheduler, independent of the FSM.
  logic [CNT_W-1:0] r_ref_cnt;
  logic [1:0]       r_digit_sel;
  logic             w_ref_last;

  assign w_ref_last = (r_ref_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ref_cnt   <= '0;
      r_digit_sel <= 2'd0;
    end else if (w_ref_last) begin
      r_ref_cnt   <= '0;
      r_digit_sel <= r_digit_sel + 2'd1;
    end else begin
      r_ref_cnt   <= r_ref_cnt + CNT_W'(1);
    end
  end

  assign o_digit_sel  = r_digit_sel;
  assign o_digit_tick = w_ref_last;

endmodule

// File: tb/tb_scan_code_display_sequencer.sv
module tb_scan_code_display_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_code_valid = 1'b0;
  logic [7:0]  i_code_data = 8'h00;
  logic        o_code_ready;
  logic [31:0] o_scan_codes;
  logic [1:0]  o_digit_sel;
  logic        o_digit_tick;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  scan_code_display_sequencer #(
    .REFRESH_DIV(4),
    .CLEAR_CODE (8'h66)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_code_valid(i_code_valid),
    .i_code_data (i_code_data),
    .o_code_ready(o_code_ready),
    .o_scan_codes(o_scan_codes),
    .o_digit_sel (o_digit_sel),
    .o_digit_tick(o_digit_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold reset, check cleared outputs, release, then pass the sync edge.
  task automatic do_reset();
    reset_n      = 1'b0;
    i_code_valid = 1'b0;
    i_code_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_scan", o_scan_codes, 32'h0);
    chk("rst_sel", {30'd0, o_digit_sel}, 32'd0);
    chk("rst_tick", {31'd0, o_digit_tick}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
  endtask

  // Present byte b and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    i_code_valid = 1'b1;
    i_code_data  = b;
    n = 0;
    while (!o_code_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    i_code_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] bb_codes [4];
  int         idx;
  logic       acc;
  int         m_cnt;
  int         m_sel;

  initial begin
    // Reset, first accept latency, release back to IDLE
    do_reset();
    @(negedge clk);
    chk("ready_after_rst", {31'd0, o_code_ready}, 32'd1);
    send(8'h16);
    @(negedge clk);
    chk("lat_edge1", o_scan_codes, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_edge2", o_scan_codes, 32'h0000_0016);
    send(8'hF0);
    send(8'h16);
    settle();
    chk("release_nochg", o_scan_codes, 32'h0000_0016);
    // Back in IDLE with last_make cleared: the same key presses again.
    send(8'h16);
    settle();
    chk("repress_idle", o_scan_codes, 32'h0000_1616);

    // Five keys with release, oldest drops out
    do_reset();
    begin
      logic [7:0] seq [5];
      seq = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
      for (int i = 0; i < 5; i++) begin
        send(seq[i]);
        send(8'hF0);
        send(seq[i]);
      end
    end
    settle();
    chk("five_keys", o_scan_codes, 32'h1E26_252E);

    // Typematic repeat and 00 filtering
    do_reset();
    send(8'h45);
    send(8'h45);
    send(8'h45);
    send(8'hF0);
    send(8'h45);
    settle();
    chk("typematic", o_scan_codes, 32'h0000_0045);
    send(8'h00);
    settle();
    chk("null_drop", o_scan_codes, 32'h0000_0045);

    // Extended prefix then clear
    do_reset();
    send(8'hE0);
    send(8'h75);
    settle();
    chk("ext_prefix", o_scan_codes, 32'h0000_0075);
    send(8'h66);
    @(negedge clk);
    chk("clear_edge1", o_scan_codes, 32'h0000_0075);
    @(posedge clk);
    @(negedge clk);
    chk("clear_edge2", o_scan_codes, 32'h0);

    // Back-to-back with valid held high
    do_reset();
    bb_codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i_code_valid = 1'b1;
      i_code_data  = bb_codes[idx];
      chk($sformatf("bb_ready%0d", k), {31'd0, o_code_ready}, {31'd0, (k % 2) == 0});
      acc = o_code_ready;
      @(posedge clk);
      if (acc && idx < 3) idx++;
    end
    #1;
    i_code_valid = 1'b0;
    settle();
    chk("bb_order", o_scan_codes, 32'h1C1B_232B);

    // Reset during SHIFT loses the pending code
    send(8'h3C);
    reset_n = 1'b0;
    #1;
    chk("rst_in_shift", o_scan_codes, 32'h0);
    chk("rst_in_shift_rdy", {31'd0, o_code_ready}, 32'd0);

    // Refresh schedule with REFRESH_DIV = 4
    do_reset();
    m_cnt = 0;
    m_sel = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("tick_c%0d", c), {31'd0, o_digit_tick}, {31'd0, m_cnt == 3});
      chk($sformatf("sel_c%0d", c), {30'd0, o_digit_sel}, m_sel);
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_sel = (m_sel + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    // Advance to a nonzero digit, then reset asynchronously between edges.
    repeat (6) @(posedge clk);
    #2;
    chk("pre_async_sel_nz", {31'd0, o_digit_sel != 2'd0}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_sel", {30'd0, o_digit_sel}, 32'd0);
    chk("async_tick", {31'd0, o_digit_tick}, 32'd0);
    chk("async_rdy", {31'd0, o_code_ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_code_display_sequencer.md
Name: scan_code_display_sequencer

Overview:
Sits between the PS/2 keyboard receiver and the seven-segment controller. Accepts decoded keyboard bytes over a valid/ready handshake and filters the PS/2 protocol bytes: extended prefix, break prefix, released-key codes and typematic repeats. Keeps a 4-deep history of pressed-key make codes as the 32-bit display word. Also generates the digit-multiplex schedule: a digit select and a refresh tick for the seven-segment controller.

Parameters:
REFRESH_DIV, 100000, clk cycles per displayed digit (1 kHz per digit at 100 MHz); must be >= 2
CLEAR_CODE, 8'h66, make code that clears the history (backspace)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
code_valid  in  1  code_data holds a received keyboard byte
code_data  in  8  keyboard byte
code_ready  out  1  sequencer can accept a byte this cycle
scan_codes  out  32  key history; [7:0] newest, [31:24] oldest; 8'h00 = empty slot
digit_sel  out  2  digit currently being driven, 0..3
digit_tick  out  1  one-cycle pulse when digit_sel advances

Behaviour:
- Reset (async assert, sync deassert into clk domain) clears all state and outputs:
  - scan_codes = 0, digit_sel = 0, digit_tick = 0, state = IDLE, last_make = 0.
  - code_ready = 1 from the first clock after release.
- A byte is accepted on a clk edge where code_valid && code_ready.
  - code_ready is 0 only in state SHIFT; the producer holds code_data until accepted.
- FSM states: IDLE, HELD, BREAK, SHIFT. Transitions on an accepted byte b:
  - Any state except SHIFT, b == 8'hE0: byte dropped, state unchanged.
  - IDLE, b == 8'hF0: go to BREAK.
  - IDLE, any other b: latch b into pending and last_make, go to SHIFT.
  - HELD, b == last_make: typematic repeat; dropped, stay in HELD.
  - HELD, b == 8'hF0: go to BREAK.
  - HELD, b is a different code: treated as a new press; latch into pending and last_make, go to SHIFT.
  - BREAK, any b other than E0: released-key code, dropped.
    - If b == last_make, clear last_make to 0 and go to IDLE; otherwise go to HELD.
- SHIFT lasts exactly one cycle, then goes to HELD. The buffer update happens on that cycle:
  - pending == CLEAR_CODE: scan_codes <= 0.
  - otherwise: scan_codes <= {scan_codes[23:0], pending}; the oldest byte is discarded.
- Latency: the new code appears on scan_codes 2 clk edges after the accepting edge.
  - Back-to-back throughput: one make code per 2 cycles.
- Byte 8'h00 is not a legal make code; it is dropped in every state.
- Refresh scheduler runs independently of the FSM and is never stalled:
  - Counter counts 0..REFRESH_DIV-1 and wraps.
  - On the terminal count, digit_tick = 1 for that cycle and digit_sel increments on the same edge (3 wraps to 0).
- A code accept and a refresh tick in the same cycle both take effect; neither delays the other.
- Reset asserted mid-SHIFT: the pending code is lost, with no partial update of scan_codes.

Test Plan:
- Reset, then send 8'h16, F0, 16 -> scan_codes = 32'h0000_0016 two edges after the first accept; F0 and the release 16 leave it unchanged; state returns to IDLE.
- Send 16, 1E, 26, 25, 2E (each followed by F0 and its release) -> scan_codes = 32'h1E26_252E; 16 is shifted out.
- Send 45, 45, 45 (held key), then F0, 45 -> scan_codes[7:0] = 45 written only once; scan_codes = 32'h0000_0045.
- Send E0, 75 -> only 75 is pushed; then send 66 (CLEAR_CODE) -> scan_codes = 0 two edges after the accept.
- Hold code_valid high with distinct codes every cycle -> code_ready toggles 1,0,1,0; no byte lost or duplicated; the 4 codes land in order.
- With REFRESH_DIV = 4, run 20 cycles -> digit_tick pulses every 4th cycle; digit_sel sequence 0,1,2,3,0; assert reset_n low mid-run -> outputs 0 immediately and asynchronously.
